// File: rtl/special_reg_bank.sv
// special_reg_bank
//   A bank of fifteen DATA_W-bit special registers addressed by 8-bit select
//   codes 1..15. Codes 0 and 16..255 are invalid. Registers can be written
//   and incremented in the same cycle. Reads return the pre-edge value with
//   one cycle of latency.
//
// Ports
//   clk       in   clock; all state changes on the rising edge
//   reset     in   synchronous, active-high reset
//   wtr_en    in   write strobe
//   wtr_sel   in   write register select code
//   wr_data   in   write data
//   inc_en    in   increment strobe
//   inc_sel   in   increment register select code
//   rd_en     in   read request
//   rd_sel    in   read register select code
//   rd_data   out  registered read data
//   rd_valid  out  one-cycle pulse marking rd_data valid
//   sel_err   out  one-cycle pulse after any strobed access with an invalid select
module special_reg_bank #(
  parameter int DATA_W  = 16,
  parameter int CORE_ID = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wtr_en,
  input  logic [7:0]        wtr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inc_en,
  input  logic [7:0]        inc_sel,
  input  logic              rd_en,
  input  logic [7:0]        rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              sel_err
);

  localparam int NUM_REGS = 15;
  // Reset value of CoreID, truncated to the register width.
  localparam logic [DATA_W-1:0] CORE_ID_RST = DATA_W'(CORE_ID);

  // Current value of every register; element gi holds select code gi+1.
  logic [DATA_W-1:0] reg_val [NUM_REGS];

  logic wtr_sel_ok;
  logic inc_sel_ok;
  logic rd_sel_ok;

  assign wtr_sel_ok = (wtr_sel >= 8'd1) && (wtr_sel <= 8'd15);
  assign inc_sel_ok = (inc_sel >= 8'd1) && (inc_sel <= 8'd15);
  assign rd_sel_ok  = (rd_sel  >= 8'd1) && (rd_sel  <= 8'd15);

  // Per-register storage. An invalid select code never matches any gi+1,
  // so invalid accesses leave every register untouched.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : gen_reg
      localparam logic [7:0] CODE = 8'(gi + 1);
      localparam logic [DATA_W-1:0] RST_VAL =
          (gi == NUM_REGS - 1) ? CORE_ID_RST : '0;

      logic              wr_hit;
      logic              inc_hit;
      logic [DATA_W-1:0] reg_q;
      logic [DATA_W-1:0] reg_d;

      assign wr_hit  = wtr_en && (wtr_sel == CODE);
      assign inc_hit = inc_en && (inc_sel == CODE);

      // Write beats a same-cycle increment to the same register.
      always_comb begin
        reg_d = reg_q;
        if (wr_hit) begin
          reg_d = wr_data;
        end else if (inc_hit) begin
          reg_d = reg_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          reg_q <= RST_VAL;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign reg_val[gi] = reg_q;
    end
  endgenerate

  // Read mux on pre-edge register values (no write/increment bypass).
  logic [DATA_W-1:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel == 8'(i + 1)) begin
        rd_mux = reg_val[i];
      end
    end
  end

  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;
  logic              rd_valid_q;
  logic              sel_err_q;
  logic              sel_err_d;

  // rd_data holds its last value when no read is requested; an invalid read
  // select yields zero (rd_mux is already zero in that case).
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = rd_sel_ok ? rd_mux : '0;
    end
  end

  // Selects are only judged while their strobe is high.
  assign sel_err_d = (wtr_en && !wtr_sel_ok) ||
                     (inc_en && !inc_sel_ok) ||
                     (rd_en  && !rd_sel_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      sel_err_q  <= sel_err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_special_reg_bank.sv
module tb_special_reg_bank;

  localparam int DATA_W  = 16;
  localparam int CORE_ID = 3;

  logic              clk;
  logic              reset;
  logic              wtr_en;
  logic [7:0]        wtr_sel;
  logic [DATA_W-1:0] wr_data;
  logic              inc_en;
  logic [7:0]        inc_sel;
  logic              rd_en;
  logic [7:0]        rd_sel;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              sel_err;

  int total = 0;
  int bad   = 0;

  special_reg_bank #(
    .DATA_W (DATA_W),
    .CORE_ID(CORE_ID)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wtr_en  (wtr_en),
    .wtr_sel (wtr_sel),
    .wr_data (wr_data),
    .inc_en  (inc_en),
    .inc_sel (inc_sel),
    .rd_en   (rd_en),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .sel_err (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic cyc(input logic rst, input logic we, input logic [7:0] ws,
                     input logic [15:0] wd, input logic ie, input logic [7:0] is,
                     input logic re, input logic [7:0] rs);
    reset   = rst;
    wtr_en  = we;
    wtr_sel = ws;
    wr_data = wd;
    inc_en  = ie;
    inc_sel = is;
    rd_en   = re;
    rd_sel  = rs;
    @(posedge clk);
    #1;
    $display("cycle: rst=%0b we=%0b ws=%0d wd=%h ie=%0b is=%0d re=%0b rs=%0d -> rd_data=%h rd_valid=%0b sel_err=%0b",
             rst, we, ws, wd, ie, is, re, rs, rd_data, rd_valid, sel_err);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Read-only cycle followed by the read-result checks.
  task automatic rd_chk(input string tag, input logic [7:0] code, input logic [15:0] exp);
    cyc(1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b1, code);
    chk({tag, "_data"}, 32'(rd_data), 32'(exp));
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
  endtask

  initial begin
    logic [15:0] exp_v;

    // Reset state
    cyc(1'b1, 1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b0, 8'd0);
    cyc(1'b1, 1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);

    // First edge after reset: read every code in successive cycles
    for (int c = 1; c <= 15; c++) begin
      exp_v = (c == 15) ? 16'd3 : 16'd0;
      rd_chk($sformatf("rst_read_%0d", c), 8'(c), exp_v);
      chk($sformatf("rst_read_err_%0d", c), 32'(sel_err), 32'd0);
    end

    // No read: rd_valid drops, rd_data holds
    cyc(1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("idle_valid", 32'(rd_valid), 32'd0);
    chk("idle_hold", 32'(rd_data), 32'h3);

    // Write R and read it in the same cycle: old value, then new
    cyc(1'b0, 1'b1, 8'd14, 16'h1234, 1'b0, 8'd0, 1'b1, 8'd14);
    chk("wr_rd_same_old", 32'(rd_data), 32'h0);
    chk("wr_rd_same_valid", 32'(rd_valid), 32'd1);
    rd_chk("wr_rd_next", 8'd14, 16'h1234);

    // ROW: write all-ones then increment wraps to zero
    cyc(1'b0, 1'b1, 8'd5, 16'hFFFF, 1'b0, 8'd0, 1'b0, 8'd0);
    rd_chk("row_ffff", 8'd5, 16'hFFFF);
    cyc(1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 8'd5, 1'b0, 8'd0);
    rd_chk("row_wrap", 8'd5, 16'h0000);

    // COL: simultaneous write and increment, write wins
    cyc(1'b0, 1'b1, 8'd6, 16'h0010, 1'b1, 8'd6, 1'b0, 8'd0);
    rd_chk("col_wr_wins", 8'd6, 16'h0010);

    // Write N and increment CURR in the same cycle
    cyc(1'b0, 1'b1, 8'd1, 16'h00AA, 1'b1, 8'd7, 1'b0, 8'd0);
    rd_chk("n_write", 8'd1, 16'h00AA);
    rd_chk("curr_inc", 8'd7, 16'h0001);

    // CoreID is incrementable and writable
    cyc(1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 8'd15, 1'b0, 8'd0);
    rd_chk("coreid_inc", 8'd15, 16'h0004);
    cyc(1'b0, 1'b1, 8'd15, 16'hBEEF, 1'b0, 8'd0, 1'b0, 8'd0);
    rd_chk("coreid_wr", 8'd15, 16'hBEEF);

    // Invalid write select 0
    cyc(1'b0, 1'b1, 8'd0, 16'hFFFF, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("bad_wsel_err", 32'(sel_err), 32'd1);
    cyc(1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("bad_wsel_pulse", 32'(sel_err), 32'd0);

    // Invalid read select 16
    cyc(1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b1, 8'd16);
    chk("bad_rsel_err", 32'(sel_err), 32'd1);
    chk("bad_rsel_data", 32'(rd_data), 32'd0);
    chk("bad_rsel_valid", 32'(rd_valid), 32'd1);
    cyc(1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("bad_rsel_pulse", 32'(sel_err), 32'd0);
    chk("bad_rsel_novalid", 32'(rd_valid), 32'd0);

    // Invalid increment select 200
    cyc(1'b0, 1'b0, 8'd0, 16'h0, 1'b1, 8'd200, 1'b0, 8'd0);
    chk("bad_isel_err", 32'(sel_err), 32'd1);

    // Invalid selects with strobes low are ignored
    cyc(1'b0, 1'b0, 8'd0, 16'h0, 1'b0, 8'd255, 1'b0, 8'd16);
    chk("no_strobe_err", 32'(sel_err), 32'd0);

    // Registers unchanged by invalid accesses
    rd_chk("keep_n", 8'd1, 16'h00AA);
    rd_chk("keep_r", 8'd14, 16'h1234);
    rd_chk("keep_col", 8'd6, 16'h0010);

    // Reset beats a same-cycle write and read of SUM
    cyc(1'b0, 1'b1, 8'd8, 16'h7777, 1'b0, 8'd0, 1'b0, 8'd0);
    cyc(1'b1, 1'b1, 8'd8, 16'h5555, 1'b0, 8'd0, 1'b1, 8'd8);
    chk("rst_pri_valid", 32'(rd_valid), 32'd0);
    chk("rst_pri_data", 32'(rd_data), 32'd0);
    rd_chk("rst_pri_sum", 8'd8, 16'h0000);
    rd_chk("rst_pri_coreid", 8'd15, 16'h0003);
    rd_chk("rst_pri_r", 8'd14, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
